dmem_bytelane: RTL and testbench



---
 rtl/dmem_bytelane.sv | 113 +++++++++++
 tb/tb_dmem_bytelane.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory for the MEM stage: little-endian B/H/W access,
// misalignment detection, post-reset sweep clear and a debug word port.
module dmem_bytelane #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH_WORDS    = 2 ** (ADDR_WIDTH - 2),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_data_in,
  input  logic                  mem_write_enable,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] du_mem_addr,
  output logic [31:0]           mem_data_out,
  output logic [31:0]           du_mem_data,
  output logic                  o_misaligned,
  output logic                  o_busy
);
  localparam int PW = ADDR_WIDTH - 2;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  logic [PW-1:0] clr_ptr;
  logic [PW-1:0] clr_nxt;
  logic [PW-1:0] widx;
  logic [PW-1:0] du_idx;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rword;
  logic [31:0]   ld;
  logic [31:0]   wdata;
  logic [3:0]    lane;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          unused_bits;

  assign unused_bits = ^{mem_addr[31:ADDR_WIDTH], du_mem_addr[1:0]};

  assign widx    = mem_addr[ADDR_WIDTH-1:2];
  assign du_idx  = du_mem_addr[ADDR_WIDTH-1:2];
  assign clr_nxt = clr_ptr + PW'(1);
  assign o_busy  = (state == CLEAR);

  always_comb begin
    o_misaligned = 1'b0;
    unique case (mem_size)
      2'b00:   o_misaligned = 1'b0;
      2'b01:   o_misaligned = mem_addr[0];
      2'b10:   o_misaligned = |mem_addr[1:0];
      default: o_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    lane  = 4'b0000;
    wdata = mem_data_in;
    unique case (mem_size)
      2'b00: begin
        lane  = 4'b0001 << mem_addr[1:0];
        wdata = {4{mem_data_in[7:0]}};
      end
      2'b01: begin
        lane  = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_data_in[15:0]}};
      end
      2'b10:   lane = 4'b1111;
      default: lane = 4'b0000;
    endcase
  end

  // clr_ptr holds the last cleared word; reset itself clears word 0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_nxt;
      if (clr_nxt == '1) state <= IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (CLEAR_ON_RESET) mem[0] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_nxt] <= '0;
    end else if (mem_write_enable && !o_misaligned) begin
      for (int b = 0; b < 4; b++)
        if (lane[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rword = mem[widx];
  assign rbyte = rword[{mem_addr[1:0], 3'b000} +: 8];
  assign rhalf = mem_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld = '0;
    unique case (mem_size)
      2'b00: ld = mem_unsigned ? {24'b0, rbyte}
                               : {{24{rbyte[7]}}, rbyte};
      2'b01: ld = mem_unsigned ? {16'b0, rhalf}
                               : {{16{rhalf[15]}}, rhalf};
      2'b10:   ld = rword;
      default: ld = '0;
    endcase
  end

  assign mem_data_out = (o_busy || o_misaligned) ? 32'b0 : ld;
  assign du_mem_data  = o_busy ? 32'b0 : mem[du_idx];
endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: sweep clear, restart,
// lane stores/loads, misalignment, read-during-write and wrap.
module tb_dmem_bytelane;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        uns = 1'b0;
  logic [7:0]  du_addr = '0;
  logic [31:0] dout;
  logic [31:0] du_data;
  logic        mis;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  dmem_bytelane #(.ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .mem_addr(addr),
    .mem_data_in(din),
    .mem_write_enable(we),
    .mem_size(size),
    .mem_unsigned(uns),
    .du_mem_addr(du_addr),
    .mem_data_out(dout),
    .du_mem_data(du_data),
    .o_misaligned(mis),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(string tag, logic [31:0] a, logic [1:0] sz,
                    logic u, logic [31:0] e);
    @(negedge clk);
    we = 1'b0; addr = a; size = sz; uns = u;
    exp_q.push_back(e);
    #1 chk(tag, dout, exp_q.pop_front());
  endtask

  task automatic du(string tag, logic [7:0] a, logic [31:0] e);
    @(negedge clk);
    du_addr = a;
    exp_q.push_back(e);
    #1 chk(tag, du_data, exp_q.pop_front());
  endtask

  task automatic st(logic [31:0] a, logic [1:0] sz, logic [31:0] d);
    @(negedge clk);
    addr = a; size = sz; din = d; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic all_zero(string tag);
    for (int w = 0; w < 64; w++) du(tag, 8'(w * 4), 32'h0);
  endtask

  int n;

  initial begin
    // sweep clear with a store attempted throughout
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_dout", dout, 32'h0);
    chk("rst_du", du_data, 32'h0);
    addr = 32'h40; size = 2'b10; din = 32'hDEADBEEF; we = 1'b1;
    rst = 1'b0;
    count_busy(n);
    we = 1'b0;
    chk("sweep_len", n, 32'd63);
    all_zero("sweep_word");

    // preload, then restart the sweep partway through
    for (int i = 30; i <= 40; i++) st(i * 4, 2'b10, 32'hA5A50000 | i);
    du("preload", 8'(35 * 4), 32'hA5A50023);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    count_busy(n);
    chk("restart_len", n, 32'd63);
    all_zero("restart_word");

    // lane stores and extended loads
    st(32'h10, 2'b10, 32'h8899AABB);
    st(32'h11, 2'b00, 32'h0000007F);
    rd("lw10", 32'h10, 2'b10, 1'b0, 32'h88997FBB);
    rd("lb13", 32'h13, 2'b00, 1'b0, 32'hFFFFFF88);
    rd("lbu13", 32'h13, 2'b00, 1'b1, 32'h00000088);
    rd("lh12", 32'h12, 2'b01, 1'b0, 32'hFFFF8899);
    rd("lhu10", 32'h10, 2'b01, 1'b1, 32'h00007FBB);

    // upper half store and debug aliasing
    st(32'h22, 2'b01, 32'h0000CAFE);
    du("du20", 8'h20, 32'hCAFE0000);
    du("du23", 8'h23, 32'hCAFE0000);

    // misaligned accesses
    @(negedge clk);
    addr = 32'h21; size = 2'b10; din = 32'hFFFFFFFF; we = 1'b1;
    #1 chk("mis_sw21", {31'b0, mis}, 32'h1);
    chk("mis_ld21", dout, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;
    du("mis_nowr", 8'h20, 32'hCAFE0000);
    @(negedge clk);
    addr = 32'h23; size = 2'b01;
    #1 chk("mis_sh23", {31'b0, mis}, 32'h1);
    addr = 32'h20; size = 2'b11;
    #1 chk("mis_sz11", {31'b0, mis}, 32'h1);
    addr = 32'h22; size = 2'b01;
    #1 chk("ok_sh22", {31'b0, mis}, 32'h0);

    // read-during-write with address wrap
    @(negedge clk);
    addr = 32'h100; size = 2'b10; din = 32'h12345678; we = 1'b1;
    exp_q.push_back(32'h0);
    #1 chk("rdw_old", dout, exp_q.pop_front());
    @(posedge clk);
    #1 we = 1'b0;
    exp_q.push_back(32'h12345678);
    chk("rdw_new", dout, exp_q.pop_front());
    du("du00", 8'h00, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
